grom_io_input: RTL and testbench
================================

// Module: grom_io_input
// PURPOSE
//  IO-space input peripheral for the grom_cpu: the read side of the ioreq bus, paired with the display output latch.
//  Synchronises and debounces NUM_SW board switches; returns debounced levels and sticky press events on CPU IO reads.
//  o_Data is zero when the block is not selected, so the top level ORs it into the CPU data_in mux alongside RAM.
// PARAMETERS
//  NUM_SW           4        number of switch inputs, 1..8; unused data bits read as 0
//  DEBOUNCE_CYCLES  250000   consecutive stable cycles before a level is accepted, >=2 (10 ms at 25 MHz)
//  PORT_BASE        8'h10    IO port number of LEVEL; EVENT is PORT_BASE+1; must be even
// PORTS
//  i_Clk      in   1        system clock; all logic on rising edge
//  i_Reset_n  in   1        synchronous reset, active low
//  i_Switch   in   NUM_SW   raw asynchronous switch inputs, 1 = pressed
//  i_Ioreq    in   1        CPU IO request
//  i_We       in   1        CPU write strobe, 1 = write, 0 = read
//  i_Addr     in   12       CPU address; port number is i_Addr[7:0]
//  i_Data     in   8        CPU write data
//  o_Data     out  8        read data, valid while o_Ack=1, else 8'h00
//  o_Ack      out  1        one-cycle read acknowledge
//  o_Irq      out  1        1 while any event bit is set
// BEHAVIOUR
//  Reset (i_Reset_n=0 at a clock edge): sync FFs, stable levels, counters, events, o_Data, o_Ack all 0.
//  Reset applied mid-debounce discards the partial count.
//  Sync: two-FF synchroniser per switch; sync = second-stage output.
//  Debounce, per switch; CNT_W = $clog2(DEBOUNCE_CYCLES):
//   - sync == stable: cnt <= 0.
//   - sync != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
//   - sync != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync, cnt <= 0.
//   - Any return of sync to stable before terminal count restarts from 0; no partial credit.
//   - Latency: raw edge to stable change = 2 + DEBOUNCE_CYCLES cycles.
//  Event: stable 0->1 sets event[i]; bit holds until cleared. Release (1->0) creates no event.
//  Decode: hit_lvl = i_Ioreq & (i_Addr[7:0]==PORT_BASE); hit_evt likewise for PORT_BASE+1.
//  i_Addr[11:8] is ignored.
//  Read (i_Ioreq=1, i_We=0, hit) in cycle N:
//   - o_Ack=1 and o_Data valid in cycle N+1, registered; 1-cycle latency, same as RAM.
//   - LEVEL returns {0, stable}; EVENT returns {0, event}, the snapshot before clear.
//   - EVENT read clears all event bits at the same edge (clear-on-read).
//   - Back-to-back reads: one ack per request cycle.
//  Write (i_Ioreq=1, i_We=1): to EVENT clears bits where i_Data=1 (W1C); to LEVEL ignored; no o_Ack for writes.
//  Simultaneous set and clear of one bit in the same cycle: set wins, so no press is lost.
//  Miss or no request: o_Ack=0 and o_Data=8'h00 next cycle; no state change.
//  o_Irq = |event, registered with the event bits; falls the cycle after a clearing read or write.
// STRUCTURE
//  grom_io_pkg:
//   - localparams IO_PORT_W=8, EVT_OFFSET=1.
//   - typedef io_port_t (8-bit port number).
//   - DATA_W=8, shared with grom_cpu and the display latch.
//  Sub-module grom_debounce (parameter DEBOUNCE_CYCLES; i_Clk, i_Reset_n, i_Raw, o_Level):
//   - holds synchroniser + counter + stable FF; instantiated NUM_SW times by generate.
//  Top of grom_io_input holds: address decode, rising-edge detect, event register, read-data register.
// TESTING (sim with DEBOUNCE_CYCLES=4, PORT_BASE=8'h10)
//  1 Reset: hold i_Reset_n=0 2 cycles with switches high -> o_Irq=0; LEVEL reads 8'h00 until debounce completes.
//  2 Bounce: toggle i_Switch[0] every 2 cycles for 40 cycles -> LEVEL stays 8'h00, EVENT 8'h00, o_Irq=0.
//  3 Clean press i_Switch[0]=1 at cycle T -> stable[0]=1 at T+6; LEVEL read=8'h01; o_Irq=1; EVENT read=8'h01.
//  4 Clear-on-read: read EVENT twice -> 8'h01 then 8'h00; o_Irq low the cycle after the first ack.
//  5 Race: event[1] set, i.e. stable[1] rises, in the same cycle as an EVENT read of 8'h01 -> read returns 8'h01; next read 8'h02.
//  6 W1C + miss: events 8'h03, write 8'h02 to port 8'h11 -> events 8'h01; read port 8'h12 -> o_Ack=0, o_Data=8'h00.
//  7 Reset mid-debounce: assert reset 3 cycles into a press -> no level change before a full 2+4 cycles after release of reset.

Source files
------------

// File: rtl/grom_io_pkg.sv
// grom_io_pkg: shared widths, port types and select codes
// for the grom_cpu IO-space peripherals.
package grom_io_pkg;

    localparam int DATA_W     = 8;
    localparam int IO_PORT_W  = 8;
    localparam int EVT_OFFSET = 1;

    typedef logic [IO_PORT_W-1:0] io_port_t;
    typedef logic [DATA_W-1:0]    io_data_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_LVL,
        SEL_EVT
    } io_sel_e;

    function automatic io_port_t evt_port(input io_port_t base);
        return base + io_port_t'(EVT_OFFSET);
    endfunction

endpackage

// File: rtl/grom_debounce.sv
// grom_debounce: two-FF synchroniser plus stable-count debouncer
// for one asynchronous switch input.
module grom_debounce
    import grom_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic i_Clk,
    input  logic i_Reset_n,
    input  logic i_Raw,
    output logic o_Level
);

    localparam int CNT_W =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TERM =
        CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= i_Raw;
            sync_2 <= sync_1;
        end
    end

    // Any return to the stable level restarts the count.
    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync_2 == stable) begin
            cnt    <= '0;
        end else if (cnt == TERM) begin
            cnt    <= '0;
            stable <= sync_2;
        end else begin
            cnt    <= cnt + 1'b1;
        end
    end

    assign o_Level = stable;

endmodule

// File: rtl/grom_io_input.sv
// grom_io_input: debounced switch levels and sticky press events
// on two CPU IO ports; read data is zero when not acknowledged.
module grom_io_input
    import grom_io_pkg::*;
#(
    parameter int       NUM_SW          = 4,
    parameter int       DEBOUNCE_CYCLES = 250000,
    parameter io_port_t PORT_BASE       = 8'h10
) (
    input  logic              i_Clk,
    input  logic              i_Reset_n,
    input  logic [NUM_SW-1:0] i_Switch,
    input  logic              i_Ioreq,
    input  logic              i_We,
    input  logic [11:0]       i_Addr,
    input  logic [7:0]        i_Data,
    output logic [7:0]        o_Data,
    output logic              o_Ack,
    output logic              o_Irq
);

    localparam io_port_t LVL_PORT = PORT_BASE;
    localparam io_port_t EVT_PORT = evt_port(PORT_BASE);

    logic [NUM_SW-1:0] level;
    logic [NUM_SW-1:0] level_d;
    logic [NUM_SW-1:0] rise;
    logic [NUM_SW-1:0] evt_q;
    logic [NUM_SW-1:0] evt_clr;
    logic [NUM_SW-1:0] evt_d;

    io_sel_e  sel;
    logic     rd;
    logic     rd_hit;
    io_data_t lvl_ext;
    io_data_t evt_ext;
    io_data_t rdata_d;
    logic     unused_bits;

    for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
        grom_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .i_Clk    (i_Clk),
            .i_Reset_n(i_Reset_n),
            .i_Raw    (i_Switch[g]),
            .o_Level  (level[g])
        );
    end

    assign rd     = i_Ioreq & ~i_We;
    assign rd_hit = rd & (sel != SEL_NONE);
    assign rise   = level & ~level_d;

    always_comb begin
        sel = SEL_NONE;
        unique case (1'b1)
            (i_Addr[7:0] == LVL_PORT): sel = SEL_LVL;
            (i_Addr[7:0] == EVT_PORT): sel = SEL_EVT;
            default:                   sel = SEL_NONE;
        endcase
    end

    always_comb begin
        lvl_ext             = '0;
        lvl_ext[NUM_SW-1:0] = level;
        evt_ext             = '0;
        evt_ext[NUM_SW-1:0] = evt_q;
    end

    // Set is OR-ed in after the clear so a fresh press survives.
    always_comb begin
        evt_clr = '0;
        if (i_Ioreq && (sel == SEL_EVT)) begin
            evt_clr = i_We ? i_Data[NUM_SW-1:0] : '1;
        end
        evt_d = (evt_q & ~evt_clr) | rise;
    end

    always_comb begin
        rdata_d = '0;
        if (rd) begin
            unique case (sel)
                SEL_LVL: rdata_d = lvl_ext;
                SEL_EVT: rdata_d = evt_ext;
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            level_d <= '0;
            evt_q   <= '0;
            o_Data  <= '0;
            o_Ack   <= 1'b0;
        end else begin
            level_d <= level;
            evt_q   <= evt_d;
            o_Data  <= rdata_d;
            o_Ack   <= rd_hit;
        end
    end

    assign o_Irq = |evt_q;

    assign unused_bits = ^{i_Addr[11:8], i_Data};

endmodule

// File: tb/tb_grom_io_input.sv
// tb_grom_io_input: directed stimulus with a window-based model
// of the debounced switch port, checked every cycle.
module tb_grom_io_input;

    localparam int NSW = 4;
    localparam int DB  = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NSW-1:0] sw;
    logic           ioreq;
    logic           we;
    logic [11:0]    addr;
    logic [7:0]     wdata;
    logic [7:0]     o_data;
    logic           o_ack;
    logic           o_irq;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    grom_io_input #(
        .NUM_SW         (NSW),
        .DEBOUNCE_CYCLES(DB),
        .PORT_BASE      (8'h10)
    ) dut (
        .i_Clk    (clk),
        .i_Reset_n(rst_n),
        .i_Switch (sw),
        .i_Ioreq  (ioreq),
        .i_We     (we),
        .i_Addr   (addr),
        .i_Data   (wdata),
        .o_Data   (o_data),
        .o_Ack    (o_ack),
        .o_Irq    (o_irq)
    );

    task automatic check(input string name,
                         input logic [7:0] act,
                         input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // A level is accepted once the last DB synchronised samples
    // all disagree with it; samples lag the raw pin by two edges.
    logic [NSW-1:0] hist [0:DB];
    logic [NSW-1:0] m_stable;
    logic [NSW-1:0] m_prev;
    logic [NSW-1:0] m_evt;
    logic [7:0]     m_data;
    logic           m_ack;
    bit             started = 0;

    always @(posedge clk) begin : p_model
        logic [NSW-1:0] clr;
        logic [NSW-1:0] nxt;
        logic           hit_l;
        logic           hit_e;
        logic           same;
        started = 1;
        if (!rst_n) begin
            for (int j = 0; j <= DB; j++) hist[j] = '0;
            m_stable = '0;
            m_prev   = '0;
            m_evt    = '0;
            m_data   = 8'h00;
            m_ack    = 1'b0;
        end else begin
            hit_l  = ioreq && (addr[7:0] == 8'h10);
            hit_e  = ioreq && (addr[7:0] == 8'h11);
            m_ack  = !we && (hit_l || hit_e);
            m_data = !m_ack ? 8'h00 :
                     hit_l  ? {4'h0, m_stable} : {4'h0, m_evt};
            clr    = hit_e ? (we ? wdata[NSW-1:0] : '1) : '0;
            m_evt  = (m_evt & ~clr) | (m_stable & ~m_prev);
            m_prev = m_stable;
            nxt    = m_stable;
            for (int b = 0; b < NSW; b++) begin
                same = 1'b0;
                for (int j = 1; j <= DB; j++)
                    if (hist[j][b] == m_stable[b]) same = 1'b1;
                if (!same) nxt[b] = ~m_stable[b];
            end
            m_stable = nxt;
            for (int j = DB; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = sw;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("cyc_ack", {7'b0, o_ack}, {7'b0, m_ack});
            check("cyc_data", o_data, m_data);
            check("cyc_irq", {7'b0, o_irq}, {7'b0, |m_evt});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic io_rd(input logic [11:0] a,
                         input logic [7:0]  exp,
                         input logic        exp_ack);
        ioreq = 1'b1;
        we    = 1'b0;
        addr  = a;
        @(negedge clk);
        ioreq = 1'b0;
        check("rd_ack", {7'b0, o_ack}, {7'b0, exp_ack});
        check("rd_data", o_data, exp);
    endtask

    task automatic io_wr(input logic [11:0] a,
                         input logic [7:0]  d);
        ioreq = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        ioreq = 1'b0;
        we    = 1'b0;
        check("wr_ack", {7'b0, o_ack}, 8'h00);
    endtask

    task automatic irq_is(input string name, input logic v);
        check(name, {7'b0, o_irq}, {7'b0, v});
    endtask

    initial begin
        rst_n = 1'b0;
        sw    = 4'hF;
        ioreq = 1'b0;
        we    = 1'b0;
        addr  = 12'h000;
        wdata = 8'h00;

        // reset with switches held high
        idle(2);
        rst_n = 1'b1;
        irq_is("rst_irq", 1'b0);
        check("rst_ack", {7'b0, o_ack}, 8'h00);
        io_rd(12'h010, 8'h00, 1'b1);
        idle(10);
        io_rd(12'h010, 8'h0F, 1'b1);
        sw = 4'h0;
        idle(10);
        io_rd(12'h011, 8'h0F, 1'b1);
        io_rd(12'h011, 8'h00, 1'b1);
        io_rd(12'h010, 8'h00, 1'b1);
        irq_is("rel_irq", 1'b0);

        // bounce never holds long enough
        for (int k = 0; k < 20; k++) begin
            sw[0] = ~sw[0];
            idle(2);
        end
        idle(8);
        io_rd(12'h010, 8'h00, 1'b1);
        io_rd(12'h011, 8'h00, 1'b1);
        irq_is("bnc_irq", 1'b0);

        // clean press: accepted six edges later
        sw = 4'h1;
        idle(5);
        io_rd(12'h010, 8'h00, 1'b1);
        io_rd(12'h010, 8'h01, 1'b1);
        irq_is("prs_irq", 1'b1);
        io_rd(12'h011, 8'h01, 1'b1);
        io_rd(12'h011, 8'h00, 1'b1);
        irq_is("cor_irq", 1'b0);

        // event[1] sets on the same edge as a clearing read
        sw = 4'h0;
        idle(10);
        sw = 4'h1;
        idle(10);
        sw = 4'h3;
        idle(6);
        io_rd(12'h011, 8'h01, 1'b1);
        io_rd(12'h011, 8'h02, 1'b1);

        // W1C, ignored LEVEL write, miss, high address bits
        sw = 4'h0;
        idle(10);
        sw = 4'h3;
        idle(10);
        irq_is("w1c_irq", 1'b1);
        io_wr(12'h011, 8'h02);
        io_wr(12'h010, 8'hFF);
        io_rd(12'h012, 8'h00, 1'b0);
        io_rd(12'hA10, 8'h03, 1'b1);
        io_rd(12'h011, 8'h01, 1'b1);

        // reset three cycles into a press restarts debounce
        sw = 4'h0;
        idle(10);
        sw = 4'h1;
        idle(3);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++)
            io_rd(12'h010, 8'h00, 1'b1);
        io_rd(12'h010, 8'h01, 1'b1);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
